sdram_cmd_seq: RTL

Per-access SDRAM command sequencer, sitting directly upstream of the RAS-to-CAS delay counter.
- Accepts one read or write request from the host side, issues ACTIVATE and pulses do_reada/do_writea into the delay counter.
- Waits for the counter's do_rw pulse, then issues READA/WRITEA with auto-precharge.
- Times the burst, CAS latency and write recovery, and returns to idle.

---
 rtl/sdram_cmd_seq.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sdram_cmd_seq.sv
// Per-access SDRAM sequencer: ACT -> wait do_rw -> READA/WRITEA (A10 auto-precharge) -> burst/CAS/recovery -> IDLE; outputs registered.
// No backpressure: requests are sampled only in IDLE and never queued. Optional auto-refresh path: SDRAM_CMD_SEQ_REFRESH_EN.
module sdram_cmd_seq #(
  parameter int BANK_W  = 2,
  parameter int ROW_W   = 12,
  parameter int COL_W   = 9,
  parameter int ADDR_W  = 23,
  parameter int RFC_CYC = 7
) (
  input  logic              clk0,
  input  logic              reset_n,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        cas_lat,
  input  logic [3:0]        burst_len,
  input  logic              do_rw,
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
  input  logic              ref_req,
  output logic              ref_ack,
`endif
  output logic              do_reada,
  output logic              do_writea,
  output logic              cs_n,
  output logic              ras_n,
  output logic              cas_n,
  output logic              we_n,
  output logic [ROW_W-1:0]  sa,
  output logic [BANK_W-1:0] ba,
  output logic              cmd_ack,
  output logic              wr_dq_oe,
  output logic              rd_valid,
  output logic              busy
);

  localparam int CNT_W = (RFC_CYC > 255) ? $clog2(RFC_CYC + 1) : 8;

  localparam logic [3:0] CMD_NOP    = 4'b0111;
  localparam logic [3:0] CMD_ACT    = 4'b0011;
  localparam logic [3:0] CMD_READA  = 4'b0101;
  localparam logic [3:0] CMD_WRITEA = 4'b0100;
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
  localparam logic [3:0] CMD_REF    = 4'b0001;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_ACT, S_WAIT_RC, S_RW, S_DONE
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
    , S_REF, S_RFC
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                rd_q, rd_d;
  logic [1:0]          cas_q, cas_d;
  logic [3:0]          bl_q, bl_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [ROW_W-1:0]    sa_d, sa_rw;
  logic [BANK_W-1:0]   ba_d;
  logic                do_reada_d, do_writea_d, cmd_ack_d, wr_dq_oe_d, rd_valid_d, busy_d;
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
  logic                ref_ack_d;
`endif

  assign {cs_n, ras_n, cas_n, we_n} = cmd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    cas_d   = cas_q;
    bl_d    = bl_q;
    case (state_q)
      S_IDLE: begin
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
        if (ref_req) state_d = S_REF;
        else if (req_read || req_write)
`else
        if (req_read || req_write)
`endif
        begin
          state_d = S_ACT;
          addr_d  = req_addr;
          rd_d    = req_read;
          cas_d   = (cas_lat == 2'd2) ? 2'd2 : 2'd3;
          bl_d    = (burst_len == 4'd0) ? 4'd1 : burst_len;
        end
      end
      S_ACT: state_d = S_WAIT_RC;
      S_WAIT_RC: begin
        // Counter value in the RW cycle; reaching 1 in DONE ends the access.
        if (do_rw) begin
          state_d = S_RW;
          cnt_d   = rd_q ? CNT_W'(cas_q) + CNT_W'(bl_q) : CNT_W'(bl_q) + CNT_W'(2);
        end
      end
      S_RW: begin
        state_d = S_DONE;
        cnt_d   = cnt_q - CNT_W'(1);
      end
      S_DONE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
      S_REF: begin
        state_d = S_RFC;
        cnt_d   = CNT_W'(RFC_CYC);
      end
      S_RFC: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered.
    sa_rw             = '0;
    sa_rw[COL_W-1:0]  = addr_d[COL_W-1:0];
    sa_rw[10]         = 1'b1;
    cmd_d       = CMD_NOP;
    sa_d        = '0;
    ba_d        = '0;
    do_reada_d  = 1'b0;
    do_writea_d = 1'b0;
    cmd_ack_d   = 1'b0;
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
    ref_ack_d   = 1'b0;
`endif
    case (state_d)
      S_ACT: begin
        cmd_d       = CMD_ACT;
        sa_d        = addr_d[COL_W +: ROW_W];
        ba_d        = addr_d[ADDR_W-1 -: BANK_W];
        do_reada_d  = rd_d;
        do_writea_d = !rd_d;
      end
      S_RW: begin
        cmd_d     = rd_d ? CMD_READA : CMD_WRITEA;
        sa_d      = sa_rw;
        ba_d      = addr_d[ADDR_W-1 -: BANK_W];
        cmd_ack_d = 1'b1;
      end
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
      S_REF: begin
        cmd_d     = CMD_REF;
        ref_ack_d = 1'b1;
      end
`endif
      default: ;
    endcase
    // Write data owns the first burst_len cycles; read data the last burst_len before IDLE.
    wr_dq_oe_d = ((state_d == S_RW) || (state_d == S_DONE)) && !rd_d && (cnt_d > CNT_W'(2));
    rd_valid_d = (state_d == S_DONE) && rd_d && (cnt_d <= CNT_W'(bl_d));
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      cas_q     <= '0;
      bl_q      <= '0;
      cmd_q     <= CMD_NOP;
      sa        <= '0;
      ba        <= '0;
      do_reada  <= 1'b0;
      do_writea <= 1'b0;
      cmd_ack   <= 1'b0;
      wr_dq_oe  <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
      ref_ack   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      cas_q     <= cas_d;
      bl_q      <= bl_d;
      cmd_q     <= cmd_d;
      sa        <= sa_d;
      ba        <= ba_d;
      do_reada  <= do_reada_d;
      do_writea <= do_writea_d;
      cmd_ack   <= cmd_ack_d;
      wr_dq_oe  <= wr_dq_oe_d;
      rd_valid  <= rd_valid_d;
      busy      <= busy_d;
`ifdef SDRAM_CMD_SEQ_REFRESH_EN
      ref_ack   <= ref_ack_d;
`endif
    end
  end

endmodule
